// File: rtl/apb3_top.sv
// APB3 master + zero-wait-state slave with a two-bank word memory, bus exported for observation.
// Define PSLVERR_CHECK_EN to flag out-of-range addresses with PSLVERR; otherwise addresses wrap modulo MEM_DEPTH.
module apb3_top #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 12,
  parameter int MEM_DEPTH = 64
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              data_valid,
  input  logic              data_dir,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic              transaction_done,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PWRITE,
  output logic              PSEL,
  output logic              PENABLE,
  output logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
);

  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
  localparam int unsigned BANK_W = IDX_W - 1;
  localparam int unsigned HALF = MEM_DEPTH / 2;

  typedef enum logic [1:0] {M_IDLE, M_SETUP, M_ACCESS} mst_state_t;
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} slv_state_t;

  mst_state_t r_mst_state, w_mst_next;
  slv_state_t w_slv_state;
  logic       w_start, w_finish;

  logic [DATA_W-1:0] memoryeven [HALF];
  logic [DATA_W-1:0] memoryodd  [HALF];

  logic [IDX_W-1:0]  w_word;
  logic [BANK_W-1:0] w_bank_idx;
  logic              w_odd;
  logic              w_in_range;
  logic [DATA_W-1:0] w_rd_word;

  // ---------------- master ----------------
  always_comb begin
    w_mst_next = r_mst_state;
    w_start    = 1'b0;
    w_finish   = 1'b0;
    PSEL       = 1'b0;
    PENABLE    = 1'b0;
    case (r_mst_state)
      M_IDLE: begin
        if (data_valid && !transaction_done) begin
          w_mst_next = M_SETUP;
          w_start    = 1'b1;
        end
      end
      M_SETUP: begin
        PSEL       = 1'b1;
        w_mst_next = M_ACCESS;
      end
      M_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (PREADY) begin
          w_mst_next = M_IDLE;
          w_finish   = 1'b1;
        end
      end
      default: w_mst_next = M_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      r_mst_state      <= M_IDLE;
      transaction_done <= 1'b0;
      PADDR            <= '0;
      PWDATA           <= '0;
      PWRITE           <= 1'b0;
    end else begin
      r_mst_state      <= w_mst_next;
      transaction_done <= w_finish;
      if (w_start) begin
        PADDR  <= addr;
        PWDATA <= data;
        PWRITE <= data_dir;
      end
    end
  end

  // ---------------- slave ----------------
  // Slave phase is decoded straight from PSEL/PENABLE so PREADY lands in the
  // same cycle as the master's ACCESS phase (zero wait states).
  always_comb begin
    w_slv_state = S_IDLE;
    if (PSEL) w_slv_state = PENABLE ? S_ACCESS : S_SETUP;
  end

  assign w_word     = PADDR[IDX_W-1:0];
  assign w_bank_idx = w_word[IDX_W-1:1];
  assign w_odd      = w_word[0];
  assign w_rd_word  = w_odd ? memoryodd[w_bank_idx] : memoryeven[w_bank_idx];
  assign PREADY     = (w_slv_state == S_ACCESS);

`ifdef PSLVERR_CHECK_EN
  assign w_in_range = (PADDR < ADDR_W'(MEM_DEPTH));
  assign PSLVERR    = PREADY && !w_in_range;
`else
  logic w_unused_addr_hi;
  assign w_unused_addr_hi = ^PADDR[ADDR_W-1:IDX_W];
  assign w_in_range       = 1'b1;
  assign PSLVERR          = 1'b0;
`endif

  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      PRDATA <= '0;
      for (int unsigned i = 0; i < HALF; i++) begin
        memoryeven[BANK_W'(i)] <= '0;
        memoryodd[BANK_W'(i)]  <= '0;
      end
    end else begin
      if (w_slv_state == S_SETUP && !PWRITE)
        PRDATA <= w_in_range ? w_rd_word : '0;
      if (w_slv_state == S_ACCESS && PWRITE && w_in_range) begin
        if (w_odd) memoryodd[w_bank_idx]  <= PWDATA;
        else       memoryeven[w_bank_idx] <= PWDATA;
      end
    end
  end

endmodule

// File: tb/tb_apb3_top.sv
// Directed bench for apb3_top: writes, reads, range handling, back-to-back requests, reset abort.
module tb_apb3_top;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              data_valid, data_dir;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              done;
  logic [ADDR_W-1:0] paddr;
  logic              pwrite, psel, penable, pready, pslverr;
  logic [DATA_W-1:0] pwdata, prdata;

  int errors = 0;
  int checks = 0;

  apb3_top #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_DEPTH(64)) dut (
    .PCLK(clk), .PRESETn(rst), .data_valid(data_valid), .data_dir(data_dir),
    .addr(addr), .data(data), .transaction_done(done),
    .PADDR(paddr), .PWRITE(pwrite), .PSEL(psel), .PENABLE(penable),
    .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request; checks every phase of the transfer at the falling edges.
  task automatic xfer(input string tag, input logic dir, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic exp_err,
                      input logic [DATA_W-1:0] exp_rd);
    @(negedge clk);
    data_valid = 1'b1; data_dir = dir; addr = a; data = d;
    @(negedge clk);
    data_valid = 1'b0;
    check({tag, ".setup"}, {62'd0, psel, penable}, 64'b10);
    check({tag, ".paddr"}, 64'(paddr), 64'(a));
    @(negedge clk);
    check({tag, ".access"}, {61'd0, psel, penable, pready}, 64'b111);
    check({tag, ".pslverr"}, 64'(pslverr), 64'(exp_err));
    check({tag, ".done_early"}, 64'(done), 64'd0);
    if (!dir) check({tag, ".prdata"}, 64'(prdata), 64'(exp_rd));
    @(negedge clk);
    check({tag, ".done"}, {62'd0, done, psel}, 64'b10);
    @(negedge clk);
    check({tag, ".done_fall"}, 64'(done), 64'd0);
  endtask

  logic [13:0] done_seq, psel_seq;

  initial begin
    rst = 1'b1; data_valid = 1'b0; data_dir = 1'b0; addr = '0; data = '0;
    repeat (2) @(negedge clk);
    check("rst.ctrl", {58'd0, psel, penable, pwrite, pready, pslverr, done}, 64'd0);
    check("rst.paddr", 64'(paddr), 64'd0);
    check("rst.pwdata", 64'(pwdata), 64'd0);
    check("rst.prdata", 64'(prdata), 64'd0);
    rst = 1'b0;

    xfer("wr8", 1'b1, 12'd8, 32'd3, 1'b0, 32'd0);
    check("mem.even4", 64'(dut.memoryeven[4]), 64'd3);
    xfer("wr7", 1'b1, 12'd7, 32'd2, 1'b0, 32'd0);
    check("mem.odd3", 64'(dut.memoryodd[3]), 64'd2);
    xfer("rd8", 1'b0, 12'd8, 32'd0, 1'b0, 32'd3);
    xfer("rd7", 1'b0, 12'd7, 32'd0, 1'b0, 32'd2);

`ifdef PSLVERR_CHECK_EN
    xfer("rd4002", 1'b0, 12'd4002, 32'd0, 1'b1, 32'd0);
    xfer("wr4002", 1'b1, 12'd4002, 32'd4, 1'b1, 32'd0);
    check("mem.even17", 64'(dut.memoryeven[17]), 64'd0);
    check("mem.even4_keep", 64'(dut.memoryeven[4]), 64'd3);
    check("mem.odd3_keep", 64'(dut.memoryodd[3]), 64'd2);
`else
    // 4002 mod 64 = 34 -> even bank word 17
    xfer("rd4002", 1'b0, 12'd4002, 32'd0, 1'b0, 32'd0);
    xfer("wr4002", 1'b1, 12'd4002, 32'd4, 1'b0, 32'd0);
    check("mem.even17", 64'(dut.memoryeven[17]), 64'd4);
    xfer("rd34", 1'b0, 12'd34, 32'd0, 1'b0, 32'd4);
`endif

    // data_valid held for 10 edges: starts at edges 1,5,9; done at 3,7,11
    @(negedge clk);
    data_valid = 1'b1; data_dir = 1'b1; addr = 12'd10; data = 32'd5;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      done_seq[k] = done;
      psel_seq[k] = psel;
      if (k == 9) data_valid = 1'b0;
    end
    check("b2b.done_seq", 64'(done_seq), 64'b00_0100_0100_0100);
    check("b2b.psel_seq", 64'(psel_seq), 64'b00_0011_0011_0011);
    check("b2b.mem", 64'(dut.memoryeven[5]), 64'd5);

    // reset asserted mid-ACCESS of write 9 @2
    @(negedge clk);
    data_valid = 1'b1; data_dir = 1'b1; addr = 12'd2; data = 32'd9;
    @(negedge clk);
    data_valid = 1'b0;
    @(posedge clk);
    #2;
    check("abort.in_access", {62'd0, psel, penable}, 64'b11);
    rst = 1'b1;
    #1;
    check("abort.idle", {61'd0, psel, penable, done}, 64'd0);
    repeat (2) @(negedge clk);
    check("abort.no_done", 64'(done), 64'd0);
    check("abort.even1", 64'(dut.memoryeven[1]), 64'd0);
    check("abort.cleared", 64'(dut.memoryeven[4]), 64'd0);
    rst = 1'b0;
    xfer("rd8_post", 1'b0, 12'd8, 32'd0, 1'b0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb3_top.md
APB3_TOP -- requirements
Module: apb3_top

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of data/PWDATA/PRDATA.
REQ-002 SHALL have parameter ADDR_W, default 12, width of addr/PADDR.
REQ-003 SHALL have parameter MEM_DEPTH, default 64, number of valid word addresses (0..MEM_DEPTH-1).
REQ-004 PCLK  input  1  single clock; all state changes on rising edge.
REQ-005 PRESETn  input  1  reset; asynchronous, active-high (1 = in reset) despite the name.
REQ-006 data_valid  input  1  user request to start one transfer.
REQ-007 data_dir  input  1  1 = write, 0 = read.
REQ-008 addr  input  ADDR_W  transfer word address.
REQ-009 data  input  DATA_W  write data.
REQ-010 transaction_done  output  1  one-cycle completion pulse.
REQ-011 PADDR, PWRITE, PSEL, PENABLE, PWDATA  output  ADDR_W/1/1/1/DATA_W  internal APB3 bus, master to slave, exported for observation.
REQ-012 PRDATA, PREADY, PSLVERR  output  DATA_W/1/1  internal APB3 bus, slave to master, exported for observation.

Function
REQ-013 SHALL contain one APB3 master and one APB3 slave connected point-to-point by the APB3 bus.
REQ-014 Master states SHALL be IDLE, SETUP, ACCESS; slave states SHALL be IDLE, SETUP, ACCESS, tracking the PSEL/PENABLE phase.
REQ-015 Master IDLE -> SETUP SHALL occur on an edge where data_valid=1 and transaction_done=0; it latches addr/data/data_dir onto PADDR/PWDATA/PWRITE.
REQ-016 Master SETUP: PSEL=1, PENABLE=0; next edge SHALL go to ACCESS unconditionally.
REQ-017 Master ACCESS: PSEL=1, PENABLE=1; stays while PREADY=0; on edge with PREADY=1 SHALL go to IDLE and set transaction_done=1 for exactly one cycle.
REQ-018 Slave SHALL drive PREADY=1 in its ACCESS state (zero wait states); latency from sampled data_valid to transaction_done rising SHALL be 3 edges.
REQ-019 Storage SHALL be two banks, memoryeven and memoryodd, each MEM_DEPTH/2 words; even address a -> memoryeven[a>>1], odd -> memoryodd[a>>1].
REQ-020 Write: slave SHALL store PWDATA on the completing ACCESS edge when PWRITE=1 and address in range.
REQ-021 Read: slave SHALL register the addressed word onto PRDATA on entry to ACCESS; PRDATA holds until the next read.
REQ-022 Address >= MEM_DEPTH SHALL assert PSLVERR=1 together with PREADY in ACCESS; write suppressed, PRDATA=0.
REQ-023 PSEL=0 in IDLE; PSLVERR=0 outside ACCESS.
REQ-024 data_valid held high after done SHALL not retrigger until transaction_done has fallen (one idle cycle minimum between transfers).

Reset
REQ-025 PRESETn=1 SHALL immediately force both FSMs to IDLE; PSEL, PENABLE, PWRITE, PREADY, PSLVERR, transaction_done = 0; PADDR, PWDATA, PRDATA = 0.
REQ-026 Both banks SHALL clear to 0 on reset.
REQ-027 Reset during SETUP/ACCESS SHALL abort the transfer with no memory write and no transaction_done.

Configuration
REQ-028 Macro PSLVERR_CHECK_EN defined: range check per REQ-022.
REQ-029 Macro PSLVERR_CHECK_EN undefined: PSLVERR tied 0; address used modulo MEM_DEPTH (low bits), all accesses complete normally.

Verification
REQ-030 After reset release: write data=3 addr=8 -> memoryeven[4]=3, one transaction_done pulse, PSLVERR=0.
REQ-031 Write data=2 addr=7 -> memoryodd[3]=2; then read addr=8 -> PRDATA=3; read addr=7 -> PRDATA=2.
REQ-032 Read addr=4002 (PSLVERR_CHECK_EN) -> PSLVERR=1 in ACCESS, PRDATA=0, transaction_done pulses once.
REQ-033 Write data=4 addr=4002 (PSLVERR_CHECK_EN) -> PSLVERR=1, no bank word changes.
REQ-034 data_valid held high for 10 cycles with one request -> transfers separated by at least one IDLE cycle, done pulses each exactly 1 cycle wide.
REQ-035 Assert PRESETn during ACCESS of write data=9 addr=2 -> FSMs IDLE immediately, memoryeven[1]=0, no transaction_done.
